// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the convolution tap MAC
//   tap_pos   : counter position of kernel tap (r,c)
//   min_sum_w : smallest accumulator width that cannot overflow over K*K taps
//   state_e   : sequencer states
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  function automatic int tap_pos(input int r, input int c, input int start,
                                 input int row_stride, input int col_stride);
    return start + r * row_stride + c * col_stride;
  endfunction

  function automatic int min_sum_w(input int dw, input int ww, input int k);
    return dw + ww + $clog2(k * k);
  endfunction

endpackage

// File: rtl/tap_mac_acc.sv
// rtl/tap_mac_acc.sv - clear/load/accumulate register with extend-and-multiply datapath
//   clk, rst    : clock, asynchronous active-high reset
//   clr_i       : start a new sum (drop the held accumulator)
//   add_i       : include data_i * weight_i in this cycle's sum
//   data_i      : DW-bit sample
//   weight_i    : WW-bit weight
//   acc_next_o  : accumulator value after this cycle's edge
module tap_mac_acc #(
  parameter int DW     = 8,
  parameter int WW     = 8,
  parameter int SUM_W  = 21,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [DW-1:0]    data_i,
  input  logic [WW-1:0]    weight_i,
  output logic [SUM_W-1:0] acc_next_o
);

  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_d;
  logic [SUM_W-1:0] prod_ext;

  if (SIGNED != 0) begin : g_signed
    logic signed [DW+WW-1:0] prod;
    // Widening before the multiply keeps the full signed product.
    assign prod     = (DW+WW)'($signed(data_i)) * (DW+WW)'($signed(weight_i));
    assign prod_ext = SUM_W'(prod);
  end else begin : g_unsigned
    logic [DW+WW-1:0] prod;
    assign prod     = (DW+WW)'(data_i) * (DW+WW)'(weight_i);
    assign prod_ext = SUM_W'(prod);
  end

  // Wraps modulo 2^SUM_W by construction; no saturation.
  assign acc_d      = (clr_i ? '0 : acc_q) + (add_i ? prod_ext : '0);
  assign acc_next_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_tap_mac.sv
// rtl/conv_tap_mac.sv - K x K convolution tap sequencer and multiply-accumulate
//   clk, rst  : clock, asynchronous active-high reset
//   in_vld    : data_col sample valid
//   cnt       : line-shift position counter
//   data_col  : K column samples, column c at [c*DW +: DW]
//   weight    : K*K kernel weights, tap (r,c) at [(r*K+c)*WW +: WW]
//   dot       : last completed dot product
//   dot_vld   : one-cycle pulse when dot updates
//   dot_err   : with dot_vld, at least one tap of the window was missed
module conv_tap_mac
  import conv_pkg::*;
#(
  parameter int DW         = 8,
  parameter int WW         = 8,
  parameter int K          = 3,
  parameter int START      = 31,
  parameter int COL_STRIDE = 2,
  parameter int ROW_STRIDE = 16,
  parameter int CNT_W      = 7,
  parameter int SUM_W      = 21,
  parameter int SIGNED     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [K*DW-1:0]      data_col,
  input  logic [K*K*WW-1:0]    weight,
  output logic [SUM_W-1:0]     dot,
  output logic                 dot_vld,
  output logic                 dot_err
);

  localparam int IW       = (K > 1) ? $clog2(K) : 1;
  localparam int LAST_TAP = tap_pos(K-1, K-1, START, ROW_STRIDE, COL_STRIDE);
  localparam logic [CNT_W-1:0] START_C = CNT_W'(START);
  localparam logic [CNT_W-1:0] COL_C   = CNT_W'(COL_STRIDE);
  localparam logic [IW-1:0]    KM1     = IW'(K-1);

  if (SUM_W < min_sum_w(DW, WW, K)) begin : g_chk_sum
    $fatal(1, "conv_tap_mac: SUM_W too narrow");
  end
  if (COL_STRIDE < 1) begin : g_chk_col
    $fatal(1, "conv_tap_mac: COL_STRIDE must be >= 1");
  end
  if (ROW_STRIDE <= (K-1) * COL_STRIDE) begin : g_chk_row
    $fatal(1, "conv_tap_mac: ROW_STRIDE overlaps columns");
  end
  if (LAST_TAP >= 2**CNT_W) begin : g_chk_cnt
    $fatal(1, "conv_tap_mac: last tap beyond counter range");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0] next_tap_q, next_tap_d;
  logic             err_q, err_d;
  logic [SUM_W-1:0] dot_q, dot_d;
  logic             dot_vld_q, dot_vld_d;
  logic             dot_err_q, dot_err_d;

  logic             start_hit, tap_hit, last_tap;
  logic [IW-1:0]    sel_row, sel_col;
  logic [DW-1:0]    data_sel;
  logic [WW-1:0]    weight_sel;
  logic [SUM_W-1:0] acc_next;

  // START wins over a tap match so a restart always re-seeds from tap (0,0).
  assign start_hit = (cnt == START_C);
  assign tap_hit   = (state_q == ACC) && (cnt == next_tap_q) && !start_hit;
  assign last_tap  = (row_q == KM1) && (col_q == KM1);
  assign sel_row   = start_hit ? '0 : row_q;
  assign sel_col   = start_hit ? '0 : col_q;

  always_comb begin
    data_sel   = '0;
    weight_sel = '0;
    for (int c = 0; c < K; c++) begin
      if (sel_col == IW'(c)) data_sel = data_col[c*DW +: DW];
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (sel_row == IW'(r) && sel_col == IW'(c)) weight_sel = weight[(r*K+c)*WW +: WW];
      end
    end
  end

  tap_mac_acc #(
    .DW     (DW),
    .WW     (WW),
    .SUM_W  (SUM_W),
    .SIGNED (SIGNED)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_hit),
    .add_i      ((start_hit || tap_hit) && in_vld),
    .data_i     (data_sel),
    .weight_i   (weight_sel),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    next_tap_d = next_tap_q;
    err_d      = err_q;
    dot_d      = dot_q;
    dot_vld_d  = 1'b0;
    dot_err_d  = dot_err_q;
    if (start_hit) begin
      err_d = !in_vld;
      row_d = '0;
      if (K == 1) begin
        dot_d     = acc_next;
        dot_vld_d = 1'b1;
        dot_err_d = !in_vld;
        col_d     = '0;
        state_d   = IDLE;
      end else begin
        col_d      = IW'(1);
        next_tap_d = START_C + COL_C;
        state_d    = ACC;
      end
    end else if (tap_hit) begin
      err_d = err_q || !in_vld;
      if (last_tap) begin
        dot_d     = acc_next;
        dot_vld_d = 1'b1;
        dot_err_d = err_q || !in_vld;
        row_d     = '0;
        col_d     = '0;
        state_d   = IDLE;
      end else if (col_q == KM1) begin
        row_d      = row_q + IW'(1);
        col_d      = '0;
        next_tap_d = CNT_W'(tap_pos(int'(row_q) + 1, 0, START, ROW_STRIDE, COL_STRIDE));
      end else begin
        col_d      = col_q + IW'(1);
        next_tap_d = next_tap_q + COL_C;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      next_tap_q <= '0;
      err_q      <= 1'b0;
      dot_q      <= '0;
      dot_vld_q  <= 1'b0;
      dot_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      next_tap_q <= next_tap_d;
      err_q      <= err_d;
      dot_q      <= dot_d;
      dot_vld_q  <= dot_vld_d;
      dot_err_q  <= dot_err_d;
    end
  end

  assign dot     = dot_q;
  assign dot_vld = dot_vld_q;
  assign dot_err = dot_err_q;

endmodule

// File: tb/tb_conv_tap_mac.sv
// tb/tb_conv_tap_mac.sv - scoreboard bench for conv_tap_mac (unsigned 3x3, signed 3x3, unsigned 5x5)
module tb_conv_tap_mac;

  typedef struct {
    logic [20:0] dot;
    logic        err;
    int          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0;
  logic [6:0] cnt0 = '0, cnt1 = '0, cnt2 = '0;
  logic [23:0]  data0 = '0, data1 = '0;
  logic [39:0]  data2 = '0;
  logic [71:0]  w0 = '0, w1 = '0;
  logic [199:0] w2 = '0;
  logic [20:0] dot0, dot1, dot2;
  logic dvld0, dvld1, dvld2, derr0, derr1, derr2;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  int prev0 = 0, prev1 = 0, prev2 = 0;

  conv_tap_mac u_dut0 (
    .clk(clk), .rst(rst0), .in_vld(vld0), .cnt(cnt0), .data_col(data0), .weight(w0),
    .dot(dot0), .dot_vld(dvld0), .dot_err(derr0)
  );

  conv_tap_mac #(.SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst1), .in_vld(vld1), .cnt(cnt1), .data_col(data1), .weight(w1),
    .dot(dot1), .dot_vld(dvld1), .dot_err(derr1)
  );

  conv_tap_mac #(.K(5), .START(0), .COL_STRIDE(1), .ROW_STRIDE(20)) u_dut2 (
    .clk(clk), .rst(rst2), .in_vld(vld2), .cnt(cnt2), .data_col(data2), .weight(w2),
    .dot(dot2), .dot_vld(dvld2), .dot_err(derr2)
  );

  task automatic check_out(input string name, input logic [20:0] gd, input logic ge,
                           input int gp, input exp_t e);
    checks++;
    if (gd !== e.dot) begin
      errors++;
      $display("FAIL %s dot got=%0h want=%0h", name, gd, e.dot);
    end
    checks++;
    if (ge !== e.err) begin
      errors++;
      $display("FAIL %s dot_err got=%0b want=%0b", name, ge, e.err);
    end
    checks++;
    if (gp != e.last) begin
      errors++;
      $display("FAIL %s pulse timing prev_cnt got=%0d want=%0d", name, gp, e.last);
    end
  endtask

  task automatic unexpected(input string name, input logic [20:0] gd);
    checks++;
    errors++;
    $display("FAIL %s unexpected dot_vld dot=%0h want=no pulse", name, gd);
  endtask

  always @(negedge clk) begin
    if (dvld0) begin
      if (q0.size() == 0) unexpected("dut0", dot0);
      else check_out("dut0", dot0, derr0, prev0, q0.pop_front());
    end
    prev0 = int'(cnt0);
  end

  always @(negedge clk) begin
    if (dvld1) begin
      if (q1.size() == 0) unexpected("dut1", dot1);
      else check_out("dut1", dot1, derr1, prev1, q1.pop_front());
    end
    prev1 = int'(cnt1);
  end

  always @(negedge clk) begin
    if (dvld2) begin
      if (q2.size() == 0) unexpected("dut2", dot2);
      else check_out("dut2", dot2, derr2, prev2, q2.pop_front());
    end
    prev2 = int'(cnt2);
  end

  task automatic ramp(input int d, input int lo, input int hi, input int miss);
    for (int v = lo; v <= hi; v++) begin
      case (d)
        0: begin cnt0 = 7'(v); vld0 = (v != miss); end
        1: begin cnt1 = 7'(v); vld1 = (v != miss); end
        default: begin cnt2 = 7'(v); vld2 = (v != miss); end
      endcase
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string name, input logic [20:0] gd, input logic gv,
                            input logic ge);
    checks++;
    if (gd !== 21'd0 || gv !== 1'b0 || ge !== 1'b0) begin
      errors++;
      $display("FAIL %s reset outputs got dot=%0h vld=%0b err=%0b want all 0", name, gd, gv, ge);
    end
  endtask

  task automatic push(input int d, input logic [20:0] dv, input logic ev, input int last);
    exp_t e;
    e.dot = dv; e.err = ev; e.last = last;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_empty(input string name, input int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s missing dot_vld pulses got=%0d pending want=0", name, n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("dut0_reset", dot0, dvld0, derr0);
    check_zero("dut1_reset", dot1, dvld1, derr1);
    check_zero("dut2_reset", dot2, dvld2, derr2);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // ramp weights 1..9, data 1
    for (int i = 0; i < 9; i++) w0[i*8 +: 8] = 8'(i + 1);
    data0 = {8'd1, 8'd1, 8'd1};
    push(0, 21'd45, 1'b0, 67);
    ramp(0, 0, 127, -1);

    // max unsigned operands
    data0 = {3{8'hFF}};
    w0 = {9{8'hFF}};
    push(0, 21'd585225, 1'b0, 67);
    ramp(0, 0, 127, -1);

    // missed tap (1,1) at cnt 49
    for (int i = 0; i < 9; i++) w0[i*8 +: 8] = 8'(i + 1);
    data0 = {8'd1, 8'd1, 8'd1};
    push(0, 21'd40, 1'b1, 67);
    ramp(0, 0, 127, 49);

    // restart at 47 -> 31, aborted window had a miss which must not stick
    data0 = {8'd3, 8'd2, 8'd1};
    push(0, 21'd96, 1'b0, 67);
    ramp(0, 0, 47, 33);
    ramp(0, 31, 127, -1);

    // asynchronous reset mid-window
    data0 = {8'd1, 8'd1, 8'd1};
    ramp(0, 0, 50, -1);
    rst0 = 1'b1;
    #1;
    check_zero("dut0_midrst", dot0, dvld0, derr0);
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    ramp(0, 51, 127, -1);
    push(0, 21'd45, 1'b0, 67);
    ramp(0, 0, 127, -1);

    // signed: -1 * 2 over nine taps
    data1 = {3{8'hFF}};
    w1 = {9{8'h02}};
    push(1, 21'h1FFFEE, 1'b0, 67);
    ramp(1, 0, 127, -1);

    // signed extremes: 127 * -128 over nine taps = -146304
    data1 = {3{8'h7F}};
    w1 = {9{8'h80}};
    push(1, 21'd1950848, 1'b0, 67);
    ramp(1, 0, 127, -1);

    // 5x5 with a reset mid-window
    data2 = {5{8'd1}};
    w2 = {25{8'd1}};
    ramp(2, 0, 50, -1);
    rst2 = 1'b1;
    #1;
    check_zero("dut2_midrst", dot2, dvld2, derr2);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    push(2, 21'd25, 1'b0, 84);
    ramp(2, 0, 127, -1);

    repeat (4) @(posedge clk);
    #1;
    check_empty("dut0", q0.size());
    check_empty("dut1", q1.size());
    check_empty("dut2", q2.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
